// File: rtl/bottle_pkg.sv
// Shared types and defaults for the tablet bottling sequencer.
// State codes double as the display code on the state output.
package bottle_pkg;

  localparam int PILL_W_DEF      = 7;
  localparam int SUM_W_DEF       = 10;
  localparam int MAX_SET_DEF     = 50;
  localparam int SWAP_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_SWAP  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

endpackage

// File: rtl/bottle_swap_timer.sv
// Loadable down-counter timing one conveyor bottle swap.
// Holds while run is low; tc flags the last swap cycle.
module bottle_swap_timer #(
  parameter int CYCLES = 4,
  parameter int CW     = $clog2(CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  output logic tc
);

  localparam logic [CW-1:0] INIT = CW'(CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  // load on swap entry, count down only while swapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= INIT;
    end else if (run && cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/bottle_seq.sv
// Batch sequencer: fills bottles tick by tick, swaps, repeats.
// Define PILL_SUM_EN to build the saturating total-pill counter.
module bottle_seq
  import bottle_pkg::*;
#(
  parameter int PILL_W      = PILL_W_DEF,
  parameter int SUM_W       = SUM_W_DEF,
  parameter int MAX_SET     = MAX_SET_DEF,
  parameter int SWAP_CYCLES = SWAP_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic [PILL_W-1:0] pill_set,
  input  logic [PILL_W-1:0] bot_set,
  output logic              gate_open,
  output logic              conveyor,
  output logic [PILL_W-1:0] pill_cnt,
  output logic [PILL_W-1:0] bot_cnt,
  output logic [SUM_W-1:0]  pill_sum,
  output logic              done,
  output logic              warning,
  output logic [2:0]        state
);

  localparam logic [PILL_W-1:0] MAX_V = PILL_W'(MAX_SET);
  localparam logic [PILL_W-1:0] ONE   = PILL_W'(1);

  state_e state_q, state_d;
  state_e ret_q, ret_d;
  state_e fill_nx;

  logic [PILL_W-1:0] pill_q, bot_q;
  logic [PILL_W-1:0] ps_q, bs_q;
  logic [PILL_W-1:0] pill_nx;

  logic latch, clr, set_bad, last;
  logic pill_inc, pill_clr, bot_inc;
  logic tmr_load, tmr_tc;
  logic gate_d, conv_d, done_d, warn_d;

  assign pill_nx = pill_q + ONE;
  assign last    = (pill_nx == ps_q);
  assign set_bad = (pill_set == '0) || (pill_set > MAX_V) ||
                   (bot_set == '0)  || (bot_set > MAX_V);

  bottle_swap_timer #(
    .CYCLES (SWAP_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .run     (state_q == ST_SWAP),
    .tc      (tmr_tc)
  );

  // state and pause return register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // next state and counter controls; stop beats everything
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    fill_nx  = ST_FILL;
    latch    = 1'b0;
    clr      = 1'b0;
    pill_inc = 1'b0;
    pill_clr = 1'b0;
    bot_inc  = 1'b0;
    tmr_load = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            latch = 1'b1;
            if (set_bad) begin
              state_d = ST_FAULT;
            end else begin
              clr     = 1'b1;
              state_d = ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (tick) begin
            pill_inc = 1'b1;
            if (last) begin
              bot_inc  = 1'b1;
              tmr_load = 1'b1;
              fill_nx  = ST_SWAP;
            end
          end
          // a completing tick with pause resumes into a full swap
          if (pause) begin
            ret_d   = fill_nx;
            state_d = ST_PAUSE;
          end else begin
            state_d = fill_nx;
          end
        end
        ST_SWAP: begin
          // the final swap cycle finishes even if pause rises
          if (tmr_tc) begin
            pill_clr = 1'b1;
            state_d  = (bot_q == bs_q) ? ST_DONE : ST_FILL;
          end else if (pause) begin
            ret_d   = ST_SWAP;
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (!pause) state_d = ret_q;
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // decode registered outputs from the next state
  always_comb begin
    gate_d = (state_d == ST_FILL);
    conv_d = (state_d == ST_SWAP);
    done_d = (state_d == ST_DONE);
    warn_d = (state_d == ST_FAULT);
  end

  // output flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_open <= 1'b0;
      conveyor  <= 1'b0;
      done      <= 1'b0;
      warning   <= 1'b0;
    end else begin
      gate_open <= gate_d;
      conveyor  <= conv_d;
      done      <= done_d;
      warning   <= warn_d;
    end
  end

  // settings latch and pill/bottle counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_q   <= '0;
      bs_q   <= '0;
      pill_q <= '0;
      bot_q  <= '0;
    end else begin
      if (latch) begin
        ps_q <= pill_set;
        bs_q <= bot_set;
      end
      if (clr) begin
        pill_q <= '0;
        bot_q  <= '0;
      end else begin
        if (pill_inc) pill_q <= pill_nx;
        else if (pill_clr) pill_q <= '0;
        if (bot_inc) bot_q <= bot_q + ONE;
      end
    end
  end

`ifdef PILL_SUM_EN
  logic [SUM_W-1:0] sum_q;

  // saturating total of every counted pill
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (pill_inc && sum_q != '1) begin
      sum_q <= sum_q + SUM_W'(1);
    end
  end

  assign pill_sum = sum_q;
`else
  assign pill_sum = '0;
`endif

  assign pill_cnt = pill_q;
  assign bot_cnt  = bot_q;
  assign state    = state_q;

endmodule

// File: tb/tb_bottle_seq.sv
// Scoreboard bench for bottle_seq with a cycle-level reference model.
// Directed scenarios first, then randomized inputs.
module tb_bottle_seq;

  localparam int SWAPC   = 4;
  localparam int MAXS    = 50;
  localparam int SUM_MAX = 1023;

  localparam int IDLE  = 0;
  localparam int FILL  = 1;
  localparam int SWAP  = 2;
  localparam int PAUSE = 3;
  localparam int DONE  = 4;
  localparam int FAULT = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic [6:0] pill_set = '0;
  logic [6:0] bot_set = '0;
  logic       gate_open, conveyor, done, warning;
  logic [6:0] pill_cnt, bot_cnt;
  logic [9:0] pill_sum;
  logic [2:0] state;

  bottle_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .pill_set  (pill_set),
    .bot_set   (bot_set),
    .gate_open (gate_open),
    .conveyor  (conveyor),
    .pill_cnt  (pill_cnt),
    .bot_cnt   (bot_cnt),
    .pill_sum  (pill_sum),
    .done      (done),
    .warning   (warning),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int pill;
    int bot;
    int sum;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;

  int m_st, m_pill, m_bot, m_sum, m_ps, m_bs, m_ret, m_left;

  task automatic model_reset();
    m_st = IDLE; m_pill = 0; m_bot = 0; m_sum = 0;
    m_ps = 0; m_bs = 0; m_ret = IDLE; m_left = 0;
  endtask

  task automatic model_step(bit tk, bit sa, bit pa, bit sp, int ps, int bs);
    int nx;
    if (sp) begin
      m_st = IDLE; m_pill = 0; m_bot = 0;
    end else begin
      case (m_st)
        IDLE, DONE: if (sa) begin
          m_ps = ps; m_bs = bs;
          if (ps == 0 || ps > MAXS || bs == 0 || bs > MAXS) m_st = FAULT;
          else begin m_pill = 0; m_bot = 0; m_st = FILL; end
        end
        FILL: begin
          nx = FILL;
          if (tk) begin
            m_pill++;
            if (m_sum < SUM_MAX) m_sum++;
            if (m_pill == m_ps) begin
              m_bot++; m_left = SWAPC; nx = SWAP;
            end
          end
          if (pa) begin m_ret = nx; m_st = PAUSE; end
          else m_st = nx;
        end
        SWAP: begin
          m_left--;
          if (m_left == 0) begin
            m_pill = 0;
            m_st = (m_bot == m_bs) ? DONE : FILL;
          end else if (pa) begin
            m_ret = SWAP; m_st = PAUSE;
          end
        end
        PAUSE: if (!pa) m_st = m_ret;
        default: ;
      endcase
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.st = m_st; e.pill = m_pill; e.bot = m_bot;
`ifdef PILL_SUM_EN
    e.sum = m_sum;
`else
    e.sum = 0;
`endif
    return e;
  endfunction

  task automatic check(string nm, exp_t e);
    bit g, c, d, w;
    g = (e.st == FILL); c = (e.st == SWAP);
    d = (e.st == DONE); w = (e.st == FAULT);
    n_cmp++;
    if (state !== 3'(e.st) || gate_open !== g || conveyor !== c ||
        done !== d || warning !== w || pill_cnt !== 7'(e.pill) ||
        bot_cnt !== 7'(e.bot) || pill_sum !== 10'(e.sum)) begin
      n_bad++;
      $display("FAIL %s cyc%0d: got st=%0d g=%b c=%b d=%b w=%b p=%0d b=%0d s=%0d want st=%0d g=%b c=%b d=%b w=%b p=%0d b=%0d s=%0d",
               nm, cyc_no, state, gate_open, conveyor, done, warning,
               pill_cnt, bot_cnt, pill_sum, e.st, g, c, d, w,
               e.pill, e.bot, e.sum);
    end
  endtask

  task automatic cyc(bit tk, bit sa, bit pa, bit sp, int ps, int bs);
    @(negedge clk);
    tick = tk; start = sa; pause = pa; stop = sp;
    pill_set = 7'(ps); bot_set = 7'(bs);
    model_step(tk, sa, pa, sp, ps & 127, bs & 127);
    q.push_back(model_exp());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // monitor: every posedge the DUT presents one registered result
  always @(posedge clk) begin
    #1;
    cyc_no++;
    if (q.size() > 0) check("seq", q.pop_front());
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    bit pa;
    int ps, bs, r;
    model_reset();
    z = model_exp();
    #3;
    check("reset", z);
    @(negedge clk);
    reset_n = 1'b1;

    // two bottles of three, ticking every cycle
    cyc(0, 1, 0, 0, 3, 2);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 3, 2);
    idle(2);

    // illegal settings
    cyc(0, 1, 0, 0, 0, 2);
    idle(2);
    cyc(0, 1, 0, 0, 3, 2);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 51, 2);
    idle(1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 2, 51);
    cyc(0, 0, 0, 1, 0, 0);

    // pause during second swap cycle, ticks ignored
    cyc(0, 1, 0, 0, 1, 3);
    cyc(1, 0, 0, 0, 1, 3);
    cyc(1, 0, 0, 0, 1, 3);
    for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0, 1, 3);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, 3);
    cyc(0, 0, 0, 1, 0, 0);

    // tick and stop together at pill_cnt 2
    cyc(0, 1, 0, 0, 5, 2);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    idle(1);

    // tick with pause in fill, including the completing tick
    cyc(0, 1, 0, 0, 2, 2);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);

    // asynchronous reset mid-fill
    cyc(0, 1, 0, 0, 5, 5);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick = 0; start = 0; pause = 0; stop = 0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst", model_exp());
    @(negedge clk);
    reset_n = 1'b1;

    // long batch to reach pill_sum saturation
    cyc(0, 1, 0, 0, 50, 50);
    for (int i = 0; i < 2800; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);

    // randomized traffic
    pa = 0; ps = 3; bs = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 9);
        ps = (r == 0) ? $urandom_range(0, 127) : $urandom_range(1, 5);
        r = $urandom_range(0, 9);
        bs = (r == 0) ? $urandom_range(0, 60) : $urandom_range(1, 3);
      end
      if ($urandom_range(0, 9) == 0) pa = ~pa;
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, pa,
          $urandom_range(0, 59) == 0, ps, bs);
    end

    @(posedge clk);
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bottle_seq.md
# bottle_seq

Batch sequencer for the tablet bottling line. Each pill-drop tick fills the current bottle. When the bottle holds the target count, the block closes the gate, pulses the conveyor to swap bottles, and repeats until the bottle target is met. It sits between the divided pill-drop timebase and the display/alarm logic and owns the pill, bottle and total counters.

## Interface
- PILL_W, 7: width of the pill and bottle counts and set values
- SUM_W, 10: width of the total-pill counter
- MAX_SET, 50: highest legal value for pill_set and bot_set
- SWAP_CYCLES, 4: clk cycles the conveyor is driven per bottle swap (≥1)
- clk  in  1  system clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle pill-drop strobe, synchronous to clk
- start  in  1  level; starts a batch from IDLE or DONE
- pause  in  1  level; freezes the batch while high
- stop  in  1  level; aborts to IDLE, has priority over all other inputs
- pill_set  in  PILL_W  pills per bottle; sampled at start
- bot_set  in  PILL_W  bottles per batch; sampled at start
- gate_open  out  1  dispensing gate; 1 only in FILL
- conveyor  out  1  bottle-advance drive; 1 only in SWAP
- pill_cnt  out  PILL_W  pills in the current bottle
- bot_cnt  out  PILL_W  bottles completed
- pill_sum  out  SUM_W  total pills since reset
- done  out  1  batch complete
- warning  out  1  illegal settings (FAULT state)
- state  out  3  current FSM state code, for display

## Operation
- States and codes: IDLE=0, FILL=1, SWAP=2, PAUSE=3, DONE=4, FAULT=5.
- IDLE/DONE + start:
  - Latch pill_set and bot_set.
  - If either latched value is 0 or greater than MAX_SET, go to FAULT.
  - Otherwise clear pill_cnt and bot_cnt and go to FILL.
- FILL + tick:
  - pill_cnt increments and pill_sum increments.
  - When the increment makes pill_cnt equal the latched pill_set, go to SWAP and increment bot_cnt.
- SWAP:
  - conveyor=1 for SWAP_CYCLES cycles, then clear pill_cnt.
  - Go to DONE if bot_cnt equals the latched bot_set, otherwise go to FILL.
  - Ticks during SWAP are discarded (gate closed).
- PAUSE:
  - Entered from FILL or SWAP when pause=1; the return state is saved.
  - All counters freeze, including the SWAP cycle counter.
  - gate_open=0 and conveyor=0; ticks are discarded.
  - When pause=0, return to the saved state and resume the SWAP countdown where it stopped.
- stop=1 from any state: next state is IDLE; pill_cnt and bot_cnt clear; pill_sum holds.
- FAULT: warning=1. Exits only to IDLE on stop.
- DONE: done=1. start begins a new batch; stop goes to IDLE.
- start in FILL, SWAP or PAUSE is ignored. Settings changed mid-batch have no effect.
- pill_sum saturates at 2^SUM_W−1; it does not wrap.

## Timing
- Reset values:
  - state=IDLE
  - all counts 0
  - gate_open=0, conveyor=0, done=0, warning=0
- All outputs are registered.
- start → FILL: state=FILL and gate_open=1 in the cycle after start is sampled.
- Final tick of a bottle: pill_cnt shows pill_set and gate_open=0 in the next cycle; conveyor rises in that same cycle.
- Swap length: conveyor stays high for exactly SWAP_CYCLES cycles, then the next state (FILL or DONE) is visible.
- Simultaneous events:
  - tick+pause in FILL: the tick is counted, then PAUSE.
  - tick+stop: stop wins and the tick is discarded.
  - pause+stop: stop wins.
- reset_n asserted mid-batch: everything returns to reset values immediately (asynchronous).

## Configuration
- PILL_SUM_EN defined: the pill_sum counter is implemented as described above.
- PILL_SUM_EN undefined: pill_sum is tied to 0 and no counter logic exists; all other behaviour is unchanged.

## Structure
- Package bottle_pkg:
  - state enum and its codes
  - MAX_SET default
  - default widths
- One sub-module, bottle_swap_timer: a loadable down-counter with hold (pause) and a terminal-count flag, driving SWAP.
- The FSM and counters live in bottle_seq.

## Test plan
- pill_set=3, bot_set=2, start, 6 ticks:
  - pill_cnt runs 1,2,3; conveyor high for 4 cycles.
  - This repeats for the second bottle, ending with bot_cnt=2, done=1, pill_sum=6.
- pill_set=0 or 51 at start: FAULT, warning=1; stop → IDLE with warning=0.
- pause for 10 cycles during SWAP cycle 2: conveyor stays 0 while paused, then conveyor=1 for the remaining 2 cycles.
- tick+stop in the same cycle with pill_cnt=2: IDLE, pill_cnt=0, pill_sum unchanged.
- tick during SWAP and during PAUSE: pill_cnt and pill_sum unchanged.
- reset_n pulled low mid-FILL: all outputs 0 asynchronously. With PILL_SUM_EN undefined, pill_sum stays 0 throughout the first scenario.
